// File: rtl/fir_tap_accumulator.sv
// fir_tap_accumulator: sums NUM_TAPS consecutive signed products into one filter sample
//   clk, reset (async, active-low), ce (global enable), flush (abort partial frame)
//   in_valid/in_ready/in_data  : product stream from the coefficient multiplier
//   out_valid/out_ready/out_data : filter sample stream, tap_cnt : next tap index
module fir_tap_accumulator #(
  parameter int DIN_WIDTH = 32,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_TAPS  = 11,
  parameter int CNT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DIN_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic        [CNT_WIDTH-1:0] tap_cnt
);
  logic signed [ACC_WIDTH-1:0] acc, din_ext, sum;
  logic in_xfer, last;
  assign din_ext  = ACC_WIDTH'(in_data);
  assign in_ready = ~out_valid & ~flush;
  assign in_xfer  = ce & in_valid & in_ready;
  assign last     = tap_cnt == CNT_WIDTH'(NUM_TAPS - 1);
  // Tap 0 restarts the sum, which also covers the single-tap case.
  assign sum      = (tap_cnt == '0) ? din_ext : acc + din_ext;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      tap_cnt   <= '0;
    end else if (ce) begin
      if (flush) begin
        acc     <= '0;
        tap_cnt <= '0;
      end else if (in_xfer) begin
        acc      <= last ? acc : sum;
        out_data <= last ? sum : out_data;
        tap_cnt  <= last ? '0 : tap_cnt + 1'b1;
      end
      out_valid <= (in_xfer & last) | (out_valid & ~out_ready);
    end
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// tb_fir_tap_accumulator: randomized and directed scoreboard bench for fir_tap_accumulator
module tb_fir_tap_accumulator;
  localparam int N = 11;
  logic clk = 0, reset = 0, ce = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0] tap_cnt;
  int vectors = 0, errors = 0;
  logic [31:0] frame[$];
  logic [31:0] exp_q[$];
  logic [31:0] out_exp = 0;

  always #5 clk = ~clk;

  fir_tap_accumulator dut (
    .clk(clk), .reset(reset), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tap_cnt(tap_cnt)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] frame_sum();
    logic [31:0] s = 0;
    foreach (frame[i]) s += frame[i];
    return s;
  endfunction

  // Reference model: a frame is a list of accepted products; a completed
  // frame's plain sum is queued as a pending sample until the consumer takes it.
  always @(negedge clk) begin
    logic rdy;
    rdy = exp_q.size() == 0 && !flush;
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, rdy);
    chk("tap_cnt", tap_cnt, frame.size());
    chk("out_data", out_data, out_exp);
    if (reset && ce) begin
      if (exp_q.size() != 0 && out_ready) chk("sample", out_data, exp_q.pop_front());
      if (flush) frame.delete();
      else if (rdy && in_valid) begin
        frame.push_back(in_data);
        if (frame.size() == N) begin
          out_exp = frame_sum();
          exp_q.push_back(out_exp);
          frame.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] d);
    int n = 0;
    logic took;
    in_valid = 1;
    in_data = d;
    do begin
      @(negedge clk);
      took = ce && reset && in_ready && !flush;
      tick();
      n++;
    end while (!took && n < 200);
    if (!took) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %h", d);
    end
  endtask

  task automatic expect_out(string name, logic [31:0] v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk(name, out_data, v);
  endtask

  task automatic model_reset();
    frame.delete();
    exp_q.delete();
    out_exp = 0;
  endtask

  initial begin
    ce = 1;
    out_ready = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tap", tap_cnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    tick();
    reset = 1;
    // basic frame
    repeat (N) send(1);
    in_valid = 0;
    expect_out("basic", 11);
    chk("basic_tap", tap_cnt, 0);
    chk("basic_bubble", in_ready, 0);
    tick();
    // signed mix
    send(5);
    send(32'hFFFF_FFFD);
    repeat (8) send(0);
    send(100);
    in_valid = 0;
    expect_out("signed", 102);
    tick();
    // two's-complement wrap
    send(32'h7FFF_FFFF);
    send(1);
    repeat (9) send(0);
    in_valid = 0;
    expect_out("wrap", 32'h8000_0000);
    tick();
    // backpressure
    out_ready = 0;
    repeat (N) send(3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 33);
      chk("bp_ready", in_ready, 0);
    end
    tick();
    out_ready = 1;
    repeat (N) send(2);
    in_valid = 0;
    expect_out("bp_next", 22);
    tick();
    // ce stall mid-frame
    repeat (4) send(4);
    chk("stall_pre", tap_cnt, 4);
    ce = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_tap", tap_cnt, 4);
    end
    tick();
    ce = 1;
    repeat (7) send(4);
    in_valid = 0;
    expect_out("stall_sum", 44);
    tick();
    // flush mid-frame
    repeat (6) send(1);
    in_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("flush_tap", tap_cnt, 0);
    repeat (N) send(1);
    in_valid = 0;
    expect_out("flush_sum", 11);
    tick();
    // asynchronous reset mid-frame
    repeat (3) send(1);
    in_valid = 0;
    chk("arst_pre", tap_cnt, 3);
    #1 reset = 0;
    model_reset();
    #1;
    chk("arst_tap", tap_cnt, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    repeat (2) tick();
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_quiet", out_valid, 0);
    end
    tick();
    // randomized traffic
    repeat (3000) begin
      ce = $urandom_range(7) != 0;
      out_ready = $urandom_range(2) != 0;
      in_valid = $urandom_range(3) != 0;
      flush = $urandom_range(39) == 0;
      in_data = $urandom_range(1) ? $urandom : 32'($urandom_range(20)) - 32'd10;
      tick();
    end
    ce = 1;
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fir_tap_accumulator.md
Name: fir_tap_accumulator

Overview:
- Downstream stage of the FIR pipelined coefficient multiplier (signed 32-bit sample × unsigned 10-bit coefficient, 32-bit product, 1-cycle latency).
- Consumes one product per tap and sums NUM_TAPS consecutive products into one filter output sample.
- Presents each sample on a valid/ready output port.
- Shares the multiplier's global clock-enable, so a pipeline stall freezes both stages together.

Parameters:
- DIN_WIDTH, 32, width of the signed product input; must equal the multiplier dout width.
- ACC_WIDTH, 32, width of the accumulator and output; must be >= DIN_WIDTH.
- NUM_TAPS, 11, number of products summed per output sample; must be >= 1.
- CNT_WIDTH, 4, width of tap_cnt; must be >= clog2(NUM_TAPS), and at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  global clock-enable; when low, all registers hold.
- flush  in  1  synchronous abort of the partial frame; effective only when ce=1.
- in_valid  in  1  product valid.
- in_ready  out  1  combinational: (~out_valid) & (~flush).
- in_data  in  DIN_WIDTH  signed product.
- out_valid  out  1  output sample valid (registered).
- out_ready  in  1  consumer ready.
- out_data  out  ACC_WIDTH  signed filter sum (registered).
- tap_cnt  out  CNT_WIDTH  index of the next tap expected (registered).

Behaviour:
- Reset (reset=0, asynchronous):
  - acc=0, out_data=0, out_valid=0, tap_cnt=0.
  - Any partial frame or undelivered sample is lost.
  - Outputs stay at these values until the first ce-qualified edge after reset deasserts.
- Input transfer: occurs at a rising edge when ce & in_valid & in_ready.
- Output transfer: occurs at a rising edge when ce & out_valid & out_ready.
- ce=0: no transfers, and acc, tap_cnt, out_valid and out_data all hold.
- Width rule:
  - in_data is sign-extended to ACC_WIDTH.
  - Sums are modulo 2^ACC_WIDTH (two's-complement wrap), with no saturation.
- Input transfer with tap_cnt < NUM_TAPS-1:
  - If tap_cnt==0, acc <= sext(in_data); otherwise acc <= acc + sext(in_data).
  - tap_cnt <= tap_cnt+1.
- Input transfer with tap_cnt == NUM_TAPS-1:
  - out_data <= acc + sext(in_data), or sext(in_data) when NUM_TAPS==1.
  - out_valid <= 1, tap_cnt <= 0.
- Latency: out_valid rises on the same edge that accepts the last tap.
- Output transfer: out_valid <= 0; out_data holds its last value.
- While out_valid=1:
  - in_ready=0, so the next frame is blocked.
  - out_data is stable until the output transfer.
- Throughput: NUM_TAPS+1 cycles per sample with continuous in_valid and out_ready=1 (one bubble per frame).
- flush=1 with ce=1:
  - tap_cnt <= 0 and acc <= 0.
  - in_ready=0, so no input is consumed that cycle.
  - A pending out_valid/out_data is not affected, and an output transfer in the same cycle still completes.
- Simultaneous output transfer and input: not possible, because in_ready=0 while out_valid=1.
- tap_cnt wrap: counts 0..NUM_TAPS-1 only.
- Protocol stability: out_valid, once high, stays high until the output transfer, including across ce=0 cycles.

Test Plan:
- Basic frame: reset, then 11 transfers of in_data=1 with out_ready=1.
  - Required: out_valid on the 11th accept edge with out_data=11, tap_cnt back to 0, then one in_ready=0 cycle.
- Signed mix: products 5, -3 (0xFFFFFFFD), 0 ×8, 100.
  - Required: out_data=102 (0x00000066).
- Wrap: products 0x7FFFFFFF, 1, then 9 zeros.
  - Required: out_data=0x80000000, with no saturation.
- Backpressure: complete a frame with out_ready=0 for 5 cycles while in_valid=1.
  - Required: out_valid and out_data stay stable and in_ready=0 throughout.
  - When out_ready=1: one output transfer, then in_ready=1 on the next cycle and the next frame accumulates from 0.
- ce stall: drop ce for 3 cycles mid-frame (tap_cnt=4) with in_valid=1.
  - Required: tap_cnt stays 4 and acc is unchanged.
  - Resuming ce yields the same sum as an unstalled frame.
- Flush and reset mid-frame:
  - flush at tap_cnt=6 → tap_cnt=0; the next 11 ones give out_data=11.
  - reset asserted asynchronously at tap_cnt=3 → tap_cnt=0 and out_valid=0 immediately, with no output produced.
